// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the stereo output mixer: register offsets, STATUS
// and CTRL bit positions, the unity volume value and the 16-bit saturation
// helper used by the mix pipeline.
// ---------------------------------------------------------------------------
package audio_pkg;

   // Register offsets (bus_addr[1:0])
   localparam logic [1:0] REG_PCM_DATA = 2'd0;
   localparam logic [1:0] REG_STATUS   = 2'd1;
   localparam logic [1:0] REG_CTRL     = 2'd2;

   // STATUS bit positions
   localparam int ST_EMPTY_BIT = 16;
   localparam int ST_FULL_BIT  = 17;
   localparam int ST_OVF_BIT   = 24;
   localparam int ST_UNF_BIT   = 25;

   // CTRL bit positions
   localparam int CTRL_PCM_EN_BIT = 16;
   localparam int CTRL_BLOCK_BIT  = 17;
   localparam int CTRL_FLUSH_BIT  = 31;

   // Volume 128 with the >>>7 post-scale gives a gain of exactly 1.0
   localparam logic [7:0] UNITY_VOL = 8'd128;

   // Clamp a scaled 26-bit mix value into the signed 16-bit output range
   function automatic logic [15:0] sat16(input logic signed [25:0] v);
      logic [15:0] res;
      if (v > 26'sd32767) begin
         res = 16'h7FFF;
      end else if (v < -26'sd32768) begin
         res = 16'h8000;
      end else begin
         res = v[15:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/audio_fifo.sv
// ---------------------------------------------------------------------------
// audio_fifo
// Synchronous FIFO holding stereo PCM words {R[31:16], L[15:0]}.
// A push is taken when not full, or when full and a pop happens in the same
// cycle. The head is presented combinationally, so a simultaneous push+pop
// reads the prior head. Flush empties the FIFO in one cycle.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   i_flush        empty the FIFO (overrides push/pop)
//   i_push, i_wr_data  write request and data
//   i_pop          read request (ignored while empty)
//   o_rd_data      current head entry
//   o_count        number of entries (0..2^AW)
//   o_full, o_empty  occupancy flags
// ---------------------------------------------------------------------------
module audio_fifo #(
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_flush,
   input  logic          i_push,
   input  logic [31:0]   i_wr_data,
   input  logic          i_pop,
   output logic [31:0]   o_rd_data,
   output logic [AW:0]   o_count,
   output logic          o_full,
   output logic          o_empty
);

   localparam logic [AW:0] DEPTH = (AW + 1)'(2 ** AW);

   logic [31:0]   r_mem [2**AW];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_pop;
   logic          w_do_push;

   assign o_full    = (r_count == DEPTH);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Storage array: written on accepted pushes only, no reset needed
   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush && !reset) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointers and occupancy count
   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/audio_mixer.sv
// ---------------------------------------------------------------------------
// audio_mixer
// Mixes the fmsynth stereo output with a CPU-fed PCM stream, applies
// per-source volume, saturates, and presents one stereo sample per tick.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   bus_addr/wrdata/wren     register write bus (addr[1:0] decoded)
//   bus_rddata               combinational read data
//   bus_wait                 stall for PCM push into a full FIFO (blocking mode)
//   fm_l, fm_r               signed FM samples
//   sample_tick              one-cycle pulse per sample period
//   audio_l, audio_r         signed mixed output, updated 3 cycles after tick
// ---------------------------------------------------------------------------
module audio_mixer
   import audio_pkg::*;
#(
   parameter int SAMPLE_DIV = 512,
   parameter int FIFO_AW    = 9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  bus_addr,
   input  logic [31:0] bus_wrdata,
   input  logic        bus_wren,
   output logic [31:0] bus_rddata,
   output logic        bus_wait,
   input  logic [15:0] fm_l,
   input  logic [15:0] fm_r,
   output logic        sample_tick,
   output logic [15:0] audio_l,
   output logic [15:0] audio_r
);

   localparam int DIV_W = $clog2(SAMPLE_DIV);

   // Divider and control/status state
   logic [DIV_W-1:0] r_div;
   logic             r_tick;
   logic [7:0]       r_fm_vol;
   logic [7:0]       r_pcm_vol;
   logic             r_pcm_en;
   logic             r_block;
   logic             r_ovf;
   logic             r_unf;
   logic             r_abort;

   // Mix pipeline
   logic [15:0]        r_fm_l, r_fm_r, r_pcm_l, r_pcm_r;
   logic               r_v1, r_v2;
   logic signed [24:0] r_pfm_l, r_pfm_r, r_ppcm_l, r_ppcm_r;
   logic [15:0]        r_audio_l, r_audio_r;

   // Bus decode and FIFO handshake
   logic               w_wr_pcm, w_wr_status, w_wr_ctrl, w_flush;
   logic               w_pop, w_push_ok, w_stall, w_drop_ovf;
   logic [31:0]        w_head;
   logic [FIFO_AW:0]   w_count;
   logic [9:0]         w_count10;
   logic               w_full, w_empty;
   logic signed [25:0] w_sum_l, w_sum_r, w_shift_l, w_shift_r;
   logic               w_unused_addr;

   assign w_unused_addr = ^bus_addr[7:2];
   assign w_wr_pcm      = bus_wren && (bus_addr[1:0] == REG_PCM_DATA);
   assign w_wr_status   = bus_wren && (bus_addr[1:0] == REG_STATUS);
   assign w_wr_ctrl     = bus_wren && (bus_addr[1:0] == REG_CTRL);
   assign w_flush       = w_wr_ctrl && bus_wrdata[CTRL_FLUSH_BIT];
   assign w_pop         = r_tick && r_pcm_en && !w_empty;
   // r_abort drops a write that was stalled when reset/flush hit
   assign w_push_ok     = w_wr_pcm && (!w_full || w_pop) && !r_abort;
   assign w_stall       = w_wr_pcm && w_full && !w_pop && !r_abort;
   assign w_drop_ovf    = w_stall && !r_block;
   assign bus_wait      = w_stall && r_block;
   assign w_count10     = 10'(w_count);

   assign sample_tick = r_tick;
   assign audio_l     = r_audio_l;
   assign audio_r     = r_audio_r;

   audio_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_flush   (w_flush),
      .i_push    (w_push_ok),
      .i_wr_data (bus_wrdata),
      .i_pop     (w_pop),
      .o_rd_data (w_head),
      .o_count   (w_count),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   // Sample-rate divider; tick is registered so it is high while r_div is at its last count
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_div  <= (r_div == DIV_W'(SAMPLE_DIV - 1)) ? '0 : r_div + 1'b1;
         r_tick <= (r_div == DIV_W'(SAMPLE_DIV - 2));
      end
   end

   // CTRL fields, sticky flags and the stall-abort marker
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fm_vol  <= UNITY_VOL;
         r_pcm_vol <= UNITY_VOL;
         r_pcm_en  <= 1'b0;
         r_block   <= 1'b0;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
         r_abort   <= bus_wait;
      end else begin
         r_abort <= w_flush && bus_wait;
         if (w_wr_ctrl) begin
            r_fm_vol  <= bus_wrdata[7:0];
            r_pcm_vol <= bus_wrdata[15:8];
            r_pcm_en  <= bus_wrdata[CTRL_PCM_EN_BIT];
            r_block   <= bus_wrdata[CTRL_BLOCK_BIT];
         end
         // A new event wins over a same-cycle write-1-to-clear
         if (w_flush) begin
            r_ovf <= 1'b0;
         end else if (w_drop_ovf) begin
            r_ovf <= 1'b1;
         end else if (w_wr_status && bus_wrdata[ST_OVF_BIT]) begin
            r_ovf <= 1'b0;
         end
         if (w_flush) begin
            r_unf <= 1'b0;
         end else if (r_tick && r_pcm_en && w_empty) begin
            r_unf <= 1'b1;
         end else if (w_wr_status && bus_wrdata[ST_UNF_BIT]) begin
            r_unf <= 1'b0;
         end
      end
   end

   assign w_sum_l   = {r_pfm_l[24], r_pfm_l} + {r_ppcm_l[24], r_ppcm_l};
   assign w_sum_r   = {r_pfm_r[24], r_pfm_r} + {r_ppcm_r[24], r_ppcm_r};
   assign w_shift_l = w_sum_l >>> 3'd7;
   assign w_shift_r = w_sum_r >>> 3'd7;

   // Mix pipeline: T capture, T+1 products (current volumes), T+2 saturate to output
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fm_l    <= '0;
         r_fm_r    <= '0;
         r_pcm_l   <= '0;
         r_pcm_r   <= '0;
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_pfm_l   <= '0;
         r_pfm_r   <= '0;
         r_ppcm_l  <= '0;
         r_ppcm_r  <= '0;
         r_audio_l <= '0;
         r_audio_r <= '0;
      end else begin
         r_v1 <= r_tick;
         r_v2 <= r_v1;
         if (r_tick) begin
            r_fm_l  <= fm_l;
            r_fm_r  <= fm_r;
            r_pcm_l <= w_pop ? w_head[15:0]  : 16'h0000;
            r_pcm_r <= w_pop ? w_head[31:16] : 16'h0000;
         end
         // Signed sample times zero-extended volume, both widened to 25 bits
         if (r_v1) begin
            r_pfm_l  <= $signed({{9{r_fm_l[15]}}, r_fm_l})   * $signed({17'd0, r_fm_vol});
            r_pfm_r  <= $signed({{9{r_fm_r[15]}}, r_fm_r})   * $signed({17'd0, r_fm_vol});
            r_ppcm_l <= $signed({{9{r_pcm_l[15]}}, r_pcm_l}) * $signed({17'd0, r_pcm_vol});
            r_ppcm_r <= $signed({{9{r_pcm_r[15]}}, r_pcm_r}) * $signed({17'd0, r_pcm_vol});
         end
         if (r_v2) begin
            r_audio_l <= sat16(w_shift_l);
            r_audio_r <= sat16(w_shift_r);
         end
      end
   end

   // Register read mux
   always_comb begin
      bus_rddata = 32'h0000_0000;
      case (bus_addr[1:0])
         REG_STATUS: begin
            bus_rddata[9:0]          = w_count10;
            bus_rddata[ST_EMPTY_BIT] = w_empty;
            bus_rddata[ST_FULL_BIT]  = w_full;
            bus_rddata[ST_OVF_BIT]   = r_ovf;
            bus_rddata[ST_UNF_BIT]   = r_unf;
         end
         REG_CTRL: begin
            bus_rddata[7:0]             = r_fm_vol;
            bus_rddata[15:8]            = r_pcm_vol;
            bus_rddata[CTRL_PCM_EN_BIT] = r_pcm_en;
            bus_rddata[CTRL_BLOCK_BIT]  = r_block;
         end
         default: bus_rddata = 32'h0000_0000;
      endcase
   end

endmodule

// File: tb/tb_audio_mixer.sv
// ---------------------------------------------------------------------------
// tb_audio_mixer
// Directed, table-driven bench for audio_mixer: reset state and tick timing,
// a vector table of mix cases, and hand-written FIFO full/blocking,
// underflow and flush sequences.
// ---------------------------------------------------------------------------
module tb_audio_mixer;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  bus_addr;
   logic [31:0] bus_wrdata;
   logic        bus_wren;
   logic [31:0] bus_rddata;
   logic        bus_wait;
   logic [15:0] fm_l, fm_r;
   logic        sample_tick;
   logic [15:0] audio_l, audio_r;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   audio_mixer dut (
      .clk         (clk),
      .reset       (reset),
      .bus_addr    (bus_addr),
      .bus_wrdata  (bus_wrdata),
      .bus_wren    (bus_wren),
      .bus_rddata  (bus_rddata),
      .bus_wait    (bus_wait),
      .fm_l        (fm_l),
      .fm_r        (fm_r),
      .sample_tick (sample_tick),
      .audio_l     (audio_l),
      .audio_r     (audio_r)
   );

   typedef struct {
      string       name;
      logic [15:0] fm_l;
      logic [15:0] fm_r;
      logic        push;
      logic [31:0] pcm;
      logic        en;
      logic [7:0]  fm_vol;
      logic [7:0]  pcm_vol;
      logic [15:0] exp_l;
      logic [15:0] exp_r;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Write one register; returns stall cycles and whether release coincided with a tick
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d,
                            output int stalls, output logic rel_tick);
      bus_addr   = {6'd0, a};
      bus_wrdata = d;
      bus_wren   = 1'b1;
      stalls     = 0;
      @(negedge clk);
      while (bus_wait && stalls < 2000) begin
         stalls++;
         @(negedge clk);
      end
      rel_tick = sample_tick;
      chk("write_wait_released", {31'd0, bus_wait}, 32'd0);
      @(posedge clk);
      #1;
      bus_wren = 1'b0;
      bus_addr = 8'd0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      int   s;
      logic t;
      bus_write(a, d, s, t);
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus_addr = {6'd0, a};
      bus_wren = 1'b0;
      @(negedge clk);
      d = bus_rddata;
      @(posedge clk);
      #1;
   endtask

   // Advance until sample_tick is high (may already be), bounded
   task automatic wait_tick();
      int n = 0;
      while (!sample_tick && n < 1200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("tick_seen", {31'd0, sample_tick}, 32'd1);
   endtask

   function automatic vec_t mk(input string nm, input logic [15:0] fl, input logic [15:0] fr,
                               input logic ps, input logic [31:0] pc, input logic en,
                               input logic [7:0] fv, input logic [7:0] pv,
                               input logic [15:0] el, input logic [15:0] er);
      vec_t v;
      v.name = nm; v.fm_l = fl; v.fm_r = fr; v.push = ps; v.pcm = pc; v.en = en;
      v.fm_vol = fv; v.pcm_vol = pv; v.exp_l = el; v.exp_r = er;
      return v;
   endfunction

   initial begin
      logic [31:0] rd;
      int          n;
      int          stalls;
      logic        rel;

      vecs[0] = mk("fm_pass",   16'h1000, 16'hF000, 1'b0, 32'h0,         1'b0, 8'd128, 8'd128, 16'h1000, 16'hF000);
      vecs[1] = mk("pcm_mix",   16'h0100, 16'h0100, 1'b1, 32'h2000_0100, 1'b1, 8'd128, 8'd128, 16'h0200, 16'h2100);
      vecs[2] = mk("sat_pos",   16'h7000, 16'h7000, 1'b1, 32'h7000_7000, 1'b1, 8'd255, 8'd255, 16'h7FFF, 16'h7FFF);
      vecs[3] = mk("sat_neg",   16'h9000, 16'h9000, 1'b1, 32'h9000_9000, 1'b1, 8'd255, 8'd255, 16'h8000, 16'h8000);
      vecs[4] = mk("half_vol",  16'h1000, 16'hF000, 1'b0, 32'h0,         1'b0, 8'd64,  8'd128, 16'h0800, 16'hF800);
      vecs[5] = mk("pcm_only",  16'h7FFF, 16'h7FFF, 1'b1, 32'hFEDC_1234, 1'b1, 8'd0,   8'd128, 16'h1234, 16'hFEDC);
      vecs[6] = mk("asr_neg",   16'hFFFF, 16'h0001, 1'b0, 32'h0,         1'b0, 8'd1,   8'd128, 16'hFFFF, 16'h0000);
      vecs[7] = mk("underflow", 16'h0010, 16'h0010, 1'b0, 32'h0,         1'b1, 8'd128, 8'd128, 16'h0010, 16'h0010);

      // Reset state and tick timing
      reset = 1'b1; bus_wren = 1'b0; bus_addr = 8'd0; bus_wrdata = 32'd0;
      fm_l = 16'd0; fm_r = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_audio_l", {16'd0, audio_l}, 32'd0);
      chk("rst_audio_r", {16'd0, audio_r}, 32'd0);
      chk("rst_tick", {31'd0, sample_tick}, 32'd0);
      chk("rst_wait", {31'd0, bus_wait}, 32'd0);
      bus_addr = 8'd1; #1;
      chk("rst_status", bus_rddata, 32'h0001_0000);
      bus_addr = 8'd2; #1;
      chk("rst_ctrl", bus_rddata, 32'h0000_8080);
      bus_addr = 8'd0; #1;
      chk("rst_pcm_read", bus_rddata, 32'h0000_0000);
      n = 0;
      while (!sample_tick && n < 1000) begin
         @(posedge clk); #1; n++;
      end
      chk("first_tick_cycle", n + 1, 32'd512);
      @(posedge clk); #1;
      chk("tick_one_cycle", {31'd0, sample_tick}, 32'd0);
      n = 1;
      while (!sample_tick && n < 1000) begin
         @(posedge clk); #1; n++;
      end
      chk("tick_period", n, 32'd512);

      // Table-driven mix vectors
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].push) begin
            wr(2'd0, vecs[i].pcm);
            bus_read(2'd1, rd);
            chk({vecs[i].name, "_count1"}, rd, 32'h0000_0001);
         end
         fm_l = vecs[i].fm_l;
         fm_r = vecs[i].fm_r;
         wr(2'd2, {15'd0, vecs[i].en, vecs[i].pcm_vol, vecs[i].fm_vol});
         wait_tick();
         repeat (3) @(posedge clk);
         #1;
         chk({vecs[i].name, "_l"}, {16'd0, audio_l}, {16'd0, vecs[i].exp_l});
         chk({vecs[i].name, "_r"}, {16'd0, audio_r}, {16'd0, vecs[i].exp_r});
         wr(2'd2, {16'd0, vecs[i].pcm_vol, vecs[i].fm_vol});
         if (vecs[i].push) begin
            bus_read(2'd1, rd);
            chk({vecs[i].name, "_count0"}, rd, 32'h0001_0000);
         end
      end

      // Underflow sticky and write-1-to-clear
      bus_read(2'd1, rd);
      chk("unf_set", rd, 32'h0201_0000);
      wr(2'd1, 32'h0300_0000);
      bus_read(2'd1, rd);
      chk("unf_cleared", rd, 32'h0001_0000);

      // Fill to full, then non-blocking overflow
      wr(2'd2, 32'h0000_8080);
      for (int i = 0; i < 512; i++) begin
         wr(2'd0, 32'h0100_0000 + i);
      end
      bus_read(2'd1, rd);
      chk("full_status", rd, 32'h0002_0200);
      wr(2'd0, 32'hDEAD_BEEF);
      bus_read(2'd1, rd);
      chk("overflow_set", rd, 32'h0102_0200);
      wr(2'd1, 32'h0100_0000);
      bus_read(2'd1, rd);
      chk("overflow_cleared", rd, 32'h0002_0200);

      // Blocking push: stalls until the tick pop frees a slot
      wait_tick();
      @(posedge clk); #1;
      wr(2'd2, 32'h0003_8080);
      bus_write(2'd0, 32'hAAAA_5555, stalls, rel);
      chk("block_stalled", {31'd0, (stalls > 0)}, 32'd1);
      chk("block_release_tick", {31'd0, rel}, 32'd1);
      bus_read(2'd1, rd);
      chk("block_count_512", rd, 32'h0002_0200);

      // Non-blocking drop while streaming, then flush mid-stream
      wr(2'd2, 32'h0001_8080);
      wr(2'd0, 32'h1111_2222);
      bus_read(2'd1, rd);
      chk("ovf_streaming", rd, 32'h0102_0200);
      wr(2'd2, 32'h8001_8080);
      bus_read(2'd1, rd);
      chk("flush_status", rd, 32'h0001_0000);
      bus_read(2'd2, rd);
      chk("flush_ctrl_read", rd, 32'h0001_8080);
      wr(2'd2, 32'h0000_8080);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
